apple_spawn_ctrl: RTL
=====================

// Module: apple_spawn_ctrl
// PURPOSE
//  Sequences apple placement for the snake game. Draws candidate positions from
//  random_grid and checks each against the snake-body occupancy checker through a
//  req/ack handshake. Retries until a free cell is found, then commits it as the
//  live apple position. Counts eaten apples and drives appleX/appleY for the
//  pixel comparator.
// PARAMETERS
//  MAX_X       630  largest legal apple X (10-px tile must fit in 640)
//  MAX_Y       470  largest legal apple Y (10-px tile must fit in 480)
//  MAX_RETRY   15   rejected candidates allowed before fallback placement
//  FALLBACK_X  320  X committed when retries are exhausted
//  FALLBACK_Y  240  Y committed when retries are exhausted
//  SCORE_W     8    score counter width
// PORTS
//  VGA_clk      in   1        sole clock, rising edge
//  reset        in   1        synchronous, active-high
//  start        in   1        game running; low forces IDLE
//  eaten        in   1        1-cycle pulse, snake head hit the apple
//  rand_X       in   10       random candidate X
//  rand_Y       in   9        random candidate Y
//  occ_req      out  1        occupancy query request
//  occ_x        out  10       queried X, stable while occ_req=1
//  occ_y        out  9        queried Y, stable while occ_req=1
//  occ_ack      in   1        checker answer valid (may arrive in the same cycle as occ_req)
//  occ_hit      in   1        1 = cell occupied by snake; sampled only with occ_ack
//  appleX       out  10       committed apple X
//  appleY       out  9        committed apple Y
//  apple_valid  out  1        apple committed and drawable
//  score        out  SCORE_W  apples eaten
//  spawn_fail   out  1        1-cycle pulse when the fallback position is used
// BEHAVIOUR
//  Reset values: state=IDLE, occ_req=0, apple_valid=0, appleX=FALLBACK_X,
//   appleY=FALLBACK_Y, score=0, spawn_fail=0, retry=0, cand=0.
//  All outputs are registered; occ_req is a Moore output, 1 iff state=QUERY.
//  IDLE: if start=1, go to SAMPLE next cycle.
//  SAMPLE: latch cand<=(rand_X,rand_Y).
//   - If rand_X>MAX_X or rand_Y>MAX_Y, increment retry and stay in SAMPLE.
//   - Otherwise go to QUERY.
//  QUERY: hold occ_req=1 with occ_x/occ_y=cand until occ_ack is seen.
//   - occ_ack & !occ_hit: commit appleX/Y<=cand, set apple_valid=1, clear retry, go to ACTIVE.
//   - occ_ack & occ_hit: increment retry, go to SAMPLE.
//  Retry limit: when a rejection would make retry==MAX_RETRY, commit FALLBACK_X/Y
//   instead, pulse spawn_fail for 1 cycle, clear retry, go to ACTIVE.
//   The fallback does not query the checker.
//  ACTIVE: on eaten=1:
//   - score<=score+1, saturating at all-ones;
//   - apple_valid<=0;
//   - go to SAMPLE.
//  Latency: eaten at cycle 0 gives SAMPLE at cycle 1, then QUERY (occ_req=1) at cycle 2.
//   If occ_ack=1 and occ_hit=0 at cycle 2, apple_valid=1 with the new position at cycle 3.
//  eaten outside ACTIVE is ignored. occ_ack outside QUERY is ignored.
//  start=0 in any state: go to IDLE next cycle, drop occ_req, clear apple_valid.
//   score and appleX/Y are held. start=0 overrides an eaten in the same cycle
//   (no increment).
//  reset overrides everything, including mid-QUERY; occ_req is 0 the cycle after.
//  apple_valid=0 throughout SAMPLE/QUERY; appleX/Y change only on commit.
// TESTING
//  1. reset, start=1, rand=(100,50), ack+!hit on first QUERY cycle ->
//     apple_valid=1 at (100,50) 3 cycles after start, score=0.
//  2. In ACTIVE, eaten pulse; first candidate hit=1, second (200,60) free ->
//     one extra SAMPLE/QUERY round; commit (200,60); score=1.
//  3. rand_X=700 -> rejected with no occ_req; next valid candidate is committed.
//  4. Every candidate hit=1 for 15 rejections -> spawn_fail pulse,
//     apple at (320,240), apple_valid=1.
//  5. Delay occ_ack 5 cycles -> occ_req and occ_x/occ_y held stable; commit the cycle after ack.
//  6. score=255 plus eaten -> stays 255. start=0 with eaten in the same cycle -> IDLE,
//     score unchanged. reset mid-QUERY -> all reset values next cycle.

Source files
------------

// File: rtl/apple_spawn_ctrl.sv
// Apple placement sequencer: draws random candidates, checks them against the
// snake occupancy checker, and commits a free cell (or a fallback) as the apple.
module apple_spawn_ctrl #(
    parameter int MAX_X      = 630,
    parameter int MAX_Y      = 470,
    parameter int MAX_RETRY  = 15,
    parameter int FALLBACK_X = 320,
    parameter int FALLBACK_Y = 240,
    parameter int SCORE_W    = 8
) (
    input  logic               VGA_clk,
    input  logic               reset,
    input  logic               start,
    input  logic               eaten,
    input  logic [9:0]         rand_X,
    input  logic [8:0]         rand_Y,
    output logic               occ_req,
    output logic [9:0]         occ_x,
    output logic [8:0]         occ_y,
    input  logic               occ_ack,
    input  logic               occ_hit,
    output logic [9:0]         appleX,
    output logic [8:0]         appleY,
    output logic               apple_valid,
    output logic [SCORE_W-1:0] score,
    output logic               spawn_fail
);

    localparam int RW = $clog2(MAX_RETRY + 1);
    localparam logic [9:0]    LIM_X      = 10'(MAX_X);
    localparam logic [8:0]    LIM_Y      = 9'(MAX_Y);
    localparam logic [9:0]    FB_X       = 10'(FALLBACK_X);
    localparam logic [8:0]    FB_Y       = 9'(FALLBACK_Y);
    localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY - 1);

    typedef enum logic [1:0] {
        IDLE,
        SAMPLE,
        QUERY,
        ACTIVE
    } state_t;

    state_t             state, state_n;
    logic [9:0]         cand_x, cand_x_n;
    logic [8:0]         cand_y, cand_y_n;
    logic [RW-1:0]      retry, retry_n;
    logic [9:0]         ax, ax_n;
    logic [8:0]         ay, ay_n;
    logic               valid, valid_n;
    logic [SCORE_W-1:0] score_q, score_n;
    logic               fail, fail_n;
    logic               req_q;
    logic               reject;

    always_ff @(posedge VGA_clk) begin
        if (reset) begin
            state   <= IDLE;
            cand_x  <= '0;
            cand_y  <= '0;
            retry   <= '0;
            ax      <= FB_X;
            ay      <= FB_Y;
            valid   <= 1'b0;
            score_q <= '0;
            fail    <= 1'b0;
            req_q   <= 1'b0;
        end else begin
            state   <= state_n;
            cand_x  <= cand_x_n;
            cand_y  <= cand_y_n;
            retry   <= retry_n;
            ax      <= ax_n;
            ay      <= ay_n;
            valid   <= valid_n;
            score_q <= score_n;
            fail    <= fail_n;
            req_q   <= (state_n == QUERY);
        end
    end

    always_comb begin
        state_n  = state;
        cand_x_n = cand_x;
        cand_y_n = cand_y;
        retry_n  = retry;
        ax_n     = ax;
        ay_n     = ay;
        valid_n  = valid;
        score_n  = score_q;
        fail_n   = 1'b0;
        reject   = 1'b0;

        if (!start) begin
            state_n = IDLE;
            valid_n = 1'b0;
            retry_n = '0;
        end else begin
            unique case (state)
                IDLE: state_n = SAMPLE;
                SAMPLE: begin
                    cand_x_n = rand_X;
                    cand_y_n = rand_Y;
                    if (rand_X > LIM_X || rand_Y > LIM_Y) reject = 1'b1;
                    else state_n = QUERY;
                end
                QUERY: begin
                    if (occ_ack) begin
                        if (occ_hit) begin
                            reject = 1'b1;
                        end else begin
                            ax_n    = cand_x;
                            ay_n    = cand_y;
                            valid_n = 1'b1;
                            retry_n = '0;
                            state_n = ACTIVE;
                        end
                    end
                end
                ACTIVE: begin
                    if (eaten) begin
                        if (score_q != '1) score_n = score_q + 1'b1;
                        valid_n = 1'b0;
                        state_n = SAMPLE;
                    end
                end
                default: state_n = IDLE;
            endcase

            // Last allowed rejection places the apple at the fixed fallback cell
            if (reject) begin
                if (retry == RETRY_LAST) begin
                    ax_n    = FB_X;
                    ay_n    = FB_Y;
                    valid_n = 1'b1;
                    fail_n  = 1'b1;
                    retry_n = '0;
                    state_n = ACTIVE;
                end else begin
                    retry_n = retry + 1'b1;
                    state_n = SAMPLE;
                end
            end
        end
    end

    assign occ_req     = req_q;
    assign occ_x       = cand_x;
    assign occ_y       = cand_y;
    assign appleX      = ax;
    assign appleY      = ay;
    assign apple_valid = valid;
    assign score       = score_q;
    assign spawn_fail  = fail;

endmodule
